// File: rtl/medac_pkg.sv
// Shared types and constants for the medac delay-sweep controller.
// Holds the FSM state encoding, the default widths and the best_err start value.
package medac_pkg;

    localparam int MEDAC_SEL_W = 4;
    localparam int MEDAC_CNT_W = 32;

    localparam logic [MEDAC_CNT_W-1:0] BEST_ERR_INIT = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SNAP0,
        S_RUN,
        S_DRAIN,
        S_SNAP1,
        S_NEXT,
        S_DONE
    } sweep_state_t;

endpackage

// File: rtl/medac_win_timer.sv
// Loadable down-counter shared by the SETTLE, RUN and DRAIN phases.
// A state loaded with N-1 lasts exactly N cycles before zero is seen.
module medac_win_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         count,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_val;
        end else if (count && (remaining != '0)) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign zero = (remaining == '0);

endmodule

// File: rtl/medac_sweep_ctrl.sv
// Sweeps the medac origin clock-delay select, measures errors per point and tracks the best select.
// Optional macro MEDAC_SWEEP_AVG_EN averages 2^REP_LOG2 windows per point.
module medac_sweep_ctrl
    import medac_pkg::*;
#(
    parameter int SEL_W      = MEDAC_SEL_W,
    parameter int CNT_W      = MEDAC_CNT_W,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 8,
    parameter int DRAIN_CYC  = 4
`ifdef MEDAC_SWEEP_AVG_EN
    ,
    parameter int REP_LOG2   = 2
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sweep_go,
    input  logic             abort,
    input  logic [SEL_W-1:0] sel_min,
    input  logic [SEL_W-1:0] sel_max,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] error_cnt,
    output logic [SEL_W-1:0] var_clk_sel,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             res_valid,
    output logic [SEL_W-1:0] res_sel,
    output logic [CNT_W-1:0] res_err,
    output logic [SEL_W-1:0] best_sel,
    output logic [CNT_W-1:0] best_err
);

    localparam logic [CNT_W-1:0] BEST_INIT   = {CNT_W{BEST_ERR_INIT[0]}};
    localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYC - 1);
    localparam logic [WIN_W-1:0] DRAIN_LOAD  = WIN_W'(DRAIN_CYC - 1);

    sweep_state_t     state;
    sweep_state_t     next_state;
    logic [SEL_W-1:0] sel_max_q;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] run_load;
    logic [WIN_W-1:0] timer_val;
    logic [CNT_W-1:0] snap0;
    logic [CNT_W-1:0] delta;
    logic [CNT_W-1:0] point_err;
    logic             timer_load;
    logic             timer_count;
    logic             timer_zero;
    logic             range_bad;
    logic             cfg_done;
    logic             last_rep;
    logic             point_valid;

    assign range_bad   = (sel_min > sel_max);
    assign run_load    = (win_len_q == '0) ? '0 : win_len_q - 1'b1;
    assign delta       = error_cnt - snap0;
    assign timer_count = (state == S_SETTLE) || (state == S_RUN) || (state == S_DRAIN);

`ifdef MEDAC_SWEEP_AVG_EN
    logic [REP_LOG2-1:0]       rep_cnt;
    logic [CNT_W+REP_LOG2-1:0] acc;
    logic [CNT_W+REP_LOG2-1:0] acc_sum;

    assign acc_sum   = acc + {{REP_LOG2{1'b0}}, delta};
    assign point_err = acc_sum[CNT_W+REP_LOG2-1:REP_LOG2];
    assign last_rep  = &rep_cnt;
`else
    assign point_err = delta;
    assign last_rep  = 1'b1;
`endif

    assign point_valid = (state == S_SNAP1) && !abort && last_rep;

    medac_win_timer #(
        .W(WIN_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .count   (timer_count),
        .load_val(timer_val),
        .zero    (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Each timed phase is entered with its timer loaded, so the load travels with the transition.
    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        timer_val  = '0;
        if (abort && (state != S_IDLE)) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sweep_go && !range_bad) begin
                        next_state = S_SETTLE;
                        timer_load = 1'b1;
                        timer_val  = SETTLE_LOAD;
                    end
                end
                S_SETTLE: if (timer_zero) next_state = S_SNAP0;
                S_SNAP0: begin
                    next_state = S_RUN;
                    timer_load = 1'b1;
                    timer_val  = run_load;
                end
                S_RUN: begin
                    if (timer_zero) begin
                        next_state = S_DRAIN;
                        timer_load = 1'b1;
                        timer_val  = DRAIN_LOAD;
                    end
                end
                S_DRAIN: if (timer_zero) next_state = S_SNAP1;
                S_SNAP1: next_state = last_rep ? S_NEXT : S_SNAP0;
                S_NEXT: begin
                    if (var_clk_sel == sel_max_q) begin
                        next_state = S_DONE;
                    end else begin
                        next_state = S_SETTLE;
                        timer_load = 1'b1;
                        timer_val  = SETTLE_LOAD;
                    end
                end
                S_DONE:  next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        start     = (state == S_RUN);
        busy      = (state != S_IDLE) && (state != S_DONE);
        done      = cfg_done || ((state == S_DONE) && !abort);
        res_valid = point_valid;
        res_sel   = var_clk_sel;
        res_err   = point_err;
    end

    // Strict less-than during an ascending sweep keeps the lower select on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
            var_clk_sel <= '0;
            sel_max_q   <= '0;
            win_len_q   <= '0;
            snap0       <= '0;
            best_sel    <= '0;
            best_err    <= BEST_INIT;
`ifdef MEDAC_SWEEP_AVG_EN
            rep_cnt     <= '0;
            acc         <= '0;
`endif
        end else begin
            cfg_done <= 1'b0;
            if ((state == S_IDLE) && sweep_go) begin
                if (range_bad) begin
                    cfg_err  <= 1'b1;
                    cfg_done <= 1'b1;
                end else begin
                    cfg_err     <= 1'b0;
                    best_err    <= BEST_INIT;
                    var_clk_sel <= sel_min;
                    sel_max_q   <= sel_max;
                    win_len_q   <= win_len;
`ifdef MEDAC_SWEEP_AVG_EN
                    rep_cnt     <= '0;
                    acc         <= '0;
`endif
                end
            end
            if ((state == S_SNAP0) && !abort) begin
                snap0 <= error_cnt;
            end
`ifdef MEDAC_SWEEP_AVG_EN
            if ((state == S_SNAP1) && !abort) begin
                rep_cnt <= rep_cnt + 1'b1;
                acc     <= last_rep ? '0 : acc_sum;
            end
`endif
            if (point_valid && (point_err < best_err)) begin
                best_sel <= var_clk_sel;
                best_err <= point_err;
            end
            if ((state == S_NEXT) && !abort && (var_clk_sel != sel_max_q)) begin
                var_clk_sel <= var_clk_sel + 1'b1;
            end
        end
    end

endmodule
